// File: rtl/txarb.sv
// txarb: round-robin whole-packet arbiter merging three
// AXI-Stream sources into one tx stream plus a per-packet tag.
module txarb #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              passThru_fifo_tvalid,
  output logic              passThru_fifo_tready,
  input  logic [DATA_W-1:0] passThru_fifo_tdata,
  input  logic              passThru_fifo_tlast,
  input  logic              slt1_fifo_tvalid,
  output logic              slt1_fifo_tready,
  input  logic [DATA_W-1:0] slt1_fifo_tdata,
  input  logic              slt1_fifo_tlast,
  input  logic              slt2_fifo_tvalid,
  output logic              slt2_fifo_tready,
  input  logic [DATA_W-1:0] slt2_fifo_tdata,
  input  logic              slt2_fifo_tlast,
  output logic              txif_fifo_tvalid,
  input  logic              txif_fifo_tready,
  output logic [DATA_W-1:0] txif_fifo_tdata,
  output logic              txif_fifo_tlast,
  output logic              tag_fifo_tvalid,
  input  logic              tag_fifo_tready,
  output logic [1:0]        tag_fifo_tdata
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STREAM,
    RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic [2:0]        req;
  logic              req_any;
  logic [1:0]        pick;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              src_rdy;
  logic              accept;

  assign req = {slt2_fifo_tvalid,
                slt1_fifo_tvalid,
                passThru_fifo_tvalid};
  assign req_any = |req;

  // Round-robin pick, starting one past the last served source.
  always_comb begin
    pick = 2'd0;
    unique case (last_grant_q)
      2'd0: pick = req[1] ? 2'd1 :
                   req[2] ? 2'd2 : 2'd0;
      2'd1: pick = req[2] ? 2'd2 :
                   req[0] ? 2'd0 : 2'd1;
      default: pick = req[0] ? 2'd0 :
                      req[1] ? 2'd1 : 2'd2;
    endcase
  end

  // Route the granted source's beat toward the output register.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    unique case (grant_q)
      2'd0: begin
        sel_valid = passThru_fifo_tvalid;
        sel_data  = passThru_fifo_tdata;
        sel_last  = passThru_fifo_tlast;
      end
      2'd1: begin
        sel_valid = slt1_fifo_tvalid;
        sel_data  = slt1_fifo_tdata;
        sel_last  = slt1_fifo_tlast;
      end
      2'd2: begin
        sel_valid = slt2_fifo_tvalid;
        sel_data  = slt2_fifo_tdata;
        sel_last  = slt2_fifo_tlast;
      end
      default: begin
        sel_valid = 1'b0;
      end
    endcase
  end

  assign src_rdy = (state_q == STREAM) &
                   (~out_valid_q | txif_fifo_tready);
  assign accept  = src_rdy & sel_valid;

  assign passThru_fifo_tready = src_rdy & (grant_q == 2'd0);
  assign slt1_fifo_tready     = src_rdy & (grant_q == 2'd1);
  assign slt2_fifo_tready     = src_rdy & (grant_q == 2'd2);

  assign tag_fifo_tvalid = (state_q == GRANT);
  assign tag_fifo_tdata  = grant_q;

  assign txif_fifo_tvalid = out_valid_q;
  assign txif_fifo_tdata  = out_data_q;
  assign txif_fifo_tlast  = out_last_q;

  // Packet-level sequencing: pick, push tag, stream, release.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (tag_fifo_tready) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept && sel_last) begin
          last_grant_d = grant_q;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        if (req_any) begin
          grant_d = pick;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load on accept, clear once drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
    end else if (txif_fifo_tready) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end
  end

  // State and datapath registers; passThru wins first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

endmodule

// File: tb/tb_txarb.sv
// tb_txarb: directed and randomized packet traffic against a
// round-robin packet-order scoreboard.
module tb_txarb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  v;
  logic [31:0] d [3];
  logic [2:0]  l;
  logic        r0, r1, r2;
  logic        txv, txl, txrdy;
  logic [31:0] txd;
  logic        tagv, tagrdy;
  logic [1:0]  tagd;

  always #5 clk = ~clk;

  txarb #(.DATA_W(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .passThru_fifo_tvalid (v[0]),
    .passThru_fifo_tready (r0),
    .passThru_fifo_tdata  (d[0]),
    .passThru_fifo_tlast  (l[0]),
    .slt1_fifo_tvalid     (v[1]),
    .slt1_fifo_tready     (r1),
    .slt1_fifo_tdata      (d[1]),
    .slt1_fifo_tlast      (l[1]),
    .slt2_fifo_tvalid     (v[2]),
    .slt2_fifo_tready     (r2),
    .slt2_fifo_tdata      (d[2]),
    .slt2_fifo_tlast      (l[2]),
    .txif_fifo_tvalid     (txv),
    .txif_fifo_tready     (txrdy),
    .txif_fifo_tdata      (txd),
    .txif_fifo_tlast      (txl),
    .tag_fifo_tvalid      (tagv),
    .tag_fifo_tready      (tagrdy),
    .tag_fifo_tdata       (tagd)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] sd [3][64];
  logic        sl [3][64];
  int          slen [3];
  int          sp [3];
  int          mp [3];
  int          pend [3];
  int          mlast;
  logic [32:0] expq [$];
  int          tagc [$];
  int          txc [$];
  int          txmode, tagmode, abort_n;
  bit          gaps;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 3; s++) begin
      slen[s] = 0;
      sp[s]   = 0;
      mp[s]   = 0;
      pend[s] = 0;
    end
    mlast = 2;
    expq.delete();
    tagc.delete();
    txc.delete();
    txmode  = 0;
    tagmode = 0;
    abort_n = 0;
    gaps    = 1'b0;
  endtask

  task automatic add_pkt(input int s, input int nb,
                         input logic [31:0] d0, input bit rnd);
    for (int i = 0; i < nb; i++) begin
      sd[s][slen[s]] = rnd ? $urandom : d0 + 32'(i);
      sl[s][slen[s]] = (i == nb - 1);
      slen[s]++;
    end
    pend[s]++;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    v      = 3'b000;
    l      = 3'b000;
    d[0]   = '0;
    d[1]   = '0;
    d[2]   = '0;
    txrdy  = 1'b1;
    tagrdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out",
          64'({txv, txl, txd, tagv, tagd, r0, r1, r2}), 64'd0);
    rst = 1'b1;
  endtask

  task automatic drive(input int cyc, input logic [2:0] hs);
    bit first;
    for (int s = 0; s < 3; s++) begin
      if (v[s] && !hs[s]) continue;
      if (sp[s] >= slen[s]) begin
        v[s] = 1'b0;
      end else begin
        first = (sp[s] == 0) || sl[s][sp[s]-1];
        if (!first && gaps && $urandom_range(3) == 0) begin
          v[s] = 1'b0;
        end else begin
          v[s] = 1'b1;
          d[s] = sd[s][sp[s]];
          l[s] = sl[s][sp[s]];
        end
      end
    end
    case (txmode)
      0:       txrdy = 1'b1;
      1:       txrdy = (cyc % 3 == 0);
      default: txrdy = ($urandom_range(9) < 7);
    endcase
    case (tagmode)
      0:       tagrdy = 1'b1;
      1:       tagrdy = (cyc >= 6);
      default: tagrdy = 1'($urandom_range(1));
    endcase
  endtask

  // Next tag: first source after the last served one that still
  // has ungranted packets.
  task automatic tag_seen(input int cyc);
    int e;
    int c;
    e = -1;
    tagc.push_back(cyc);
    for (int k = 1; k <= 3; k++) begin
      c = (mlast + k) % 3;
      if (e < 0 && pend[c] > 0) e = c;
    end
    if (e < 0) begin
      check("tag_extra", 64'd1, 64'd0);
    end else begin
      check("tag", 64'(tagd), 64'(e));
      pend[e]--;
      mlast = e;
      do begin
        expq.push_back({sl[e][mp[e]], sd[e][mp[e]]});
        mp[e]++;
      end while (!sl[e][mp[e]-1]);
    end
  endtask

  task automatic run(input int maxc);
    int          cyc;
    int          src0n;
    logic [2:0]  hs;
    logic [2:0]  rdy;
    bit          pstall, ptstall, plat, done;
    logic [33:0] pprev;
    logic [2:0]  ptag;
    logic [32:0] platv;
    cyc = 0; src0n = 0; hs = '0; done = 1'b0;
    pstall = 1'b0; ptstall = 1'b0; plat = 1'b0;
    pprev = '0; ptag = '0; platv = '0;
    drive(0, hs);
    while (cyc < maxc) begin
      @(negedge clk);
      rdy = {r2, r1, r0};
      if (pstall)
        check("tx_hold", 64'({txv, txl, txd}), 64'(pprev));
      if (ptstall)
        check("tag_hold", 64'({tagv, tagd}), 64'(ptag));
      if (plat)
        check("latency", 64'({txv, txl, txd}),
              64'({1'b1, platv}));
      if (txv && !txrdy)
        check("bp_ready", 64'(rdy), 64'd0);
      if (tagv)
        check("grant_ready", 64'(rdy), 64'd0);
      check("onehot", 64'($countones(rdy) > 1), 64'd0);
      hs   = v & rdy;
      plat = 1'b0;
      for (int s = 0; s < 3; s++)
        if (hs[s]) begin
          plat  = 1'b1;
          platv = {l[s], d[s]};
        end
      if (hs[0]) src0n++;
      if (txv && txrdy) begin
        txc.push_back(cyc);
        if (expq.size() == 0)
          check("spurious", 64'd1, 64'd0);
        else
          check("beat", 64'({txl, txd}),
                64'(expq.pop_front()));
      end
      if (tagv && tagrdy) tag_seen(cyc);
      pstall  = txv && !txrdy;
      pprev   = {txv, txl, txd};
      ptstall = tagv && !tagrdy;
      ptag    = {tagv, tagd};
      done = (expq.size() == 0) && !(txv && !txrdy);
      for (int s = 0; s < 3; s++)
        if (pend[s] != 0 || sp[s] + int'(hs[s]) < slen[s])
          done = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      for (int s = 0; s < 3; s++)
        if (hs[s]) sp[s]++;
      if (abort_n > 0 && src0n >= abort_n) break;
      if (done) break;
      drive(cyc, hs);
    end
    if (abort_n == 0) check("done", 64'(done), 64'd1);
  endtask

  initial begin
    clear_model();
    do_reset();

    // Single passThru packet, no backpressure.
    add_pkt(0, 4, 32'hA0, 1'b0);
    run(100);
    check("s1_tagcyc", 64'(tagc[0]), 64'd1);
    for (int i = 0; i < 4; i++)
      check("s1_beatcyc", 64'(txc[i]), 64'(3 + i));

    // All three request from reset, two rounds.
    clear_model();
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 3; s++)
        add_pkt(s, 2, 32'(s * 256 + r * 16), 1'b0);
    run(200);
    check("s2_ntags", 64'(tagc.size()), 64'd6);

    // Output backpressure pattern 1,0,0 on slot 1.
    clear_model();
    do_reset();
    txmode = 1;
    add_pkt(1, 6, 32'h1100, 1'b0);
    run(200);
    check("s3_nbeats", 64'(txc.size()), 64'd6);

    // Tag FIFO stalled for 5 GRANT cycles on slot 2.
    clear_model();
    do_reset();
    tagmode = 1;
    add_pkt(2, 3, 32'h2200, 1'b0);
    run(100);
    check("s4_tagcyc", 64'(tagc[0]), 64'd6);
    check("s4_first", 64'(txc[0]), 64'd8);

    // Back-to-back single-beat packets on slot 1.
    clear_model();
    do_reset();
    for (int i = 0; i < 4; i++)
      add_pkt(1, 1, 32'(32'h5100 + i), 1'b0);
    run(100);
    for (int i = 0; i < 3; i++)
      check("s5_gap", 64'(txc[i+1] - txc[i]), 64'd3);

    // Reset in the middle of a passThru packet.
    clear_model();
    do_reset();
    add_pkt(0, 5, 32'hB0, 1'b0);
    abort_n = 2;
    run(100);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst",
          64'({txv, txl, txd, tagv, tagd, r0, r1, r2}), 64'd0);
    do_reset();
    clear_model();
    add_pkt(1, 2, 32'hC100, 1'b0);
    run(100);
    check("s6_tagcyc", 64'(tagc[0]), 64'd1);
    check("s6_nbeats", 64'(txc.size()), 64'd2);

    // Randomized traffic with backpressure and in-packet gaps.
    for (int r = 0; r < 6; r++) begin
      clear_model();
      do_reset();
      txmode  = 2;
      tagmode = 2;
      gaps    = 1'b1;
      for (int s = 0; s < 3; s++) begin
        int np;
        np = $urandom_range(4);
        for (int p = 0; p < np; p++)
          add_pkt(s, $urandom_range(1, 6), 32'd0, 1'b1);
      end
      run(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
